// File: rtl/ecc_scrub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub_ctrl_if
// Brief    : Memory port bundle between the ECC scrubber (master) and the
//            SRAM arbiter (slave). Request side is held stable until mem_gnt.
// Revision : 1.0 - initial release
// ============================================================================
interface ecc_scrub_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [7:0]        mem_wchk;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic [7:0]        mem_rchk;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wchk,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rchk
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wchk,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rchk
    );
endinterface
`default_nettype wire

// File: rtl/ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub_ctrl
// Brief    : Background SRAM scrubber. Visits one word every INTERVAL idle
//            cycles, passes it through an external single-error corrector
//            and writes it back only when the corrector changed the data.
//            Counts corrections (saturating) and pulses pass_done after the
//            last word of each pass.
//            Optional macro ECC_SCRUB_LOG_EN adds log_valid/log_addr, which
//            capture the address of the first correction after reset.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_scrub_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scrub_en,
    ecc_scrub_ctrl_if.master   mem,
    output logic [31:0]        cor_din,
    output logic [7:0]         cor_chk,
    output logic               cor_en,
    input  logic [31:0]        cor_dout,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               pass_done,
    output logic               busy
`ifdef ECC_SCRUB_LOG_EN
    ,
    output logic               log_valid,
    output logic [ADDR_W-1:0]  log_addr
`endif
);

    localparam int                c_TMR_W      = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_RELOAD = c_TMR_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_CORR    = 3'd4,
        S_CMP     = 3'd5,
        S_WR_REQ  = 3'd6,
        S_NEXT    = 3'd7
    } state_t;

    state_t              r_state;
    logic [c_TMR_W-1:0]  r_timer;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;      // raw word as read from SRAM
    logic [7:0]          r_chk;       // raw check bits as read from SRAM
    logic [31:0]         r_corr;      // corrector result for r_data/r_chk
    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_wdata;
    logic [7:0]          r_mem_wchk;
    logic [31:0]         r_cor_din;
    logic [7:0]          r_cor_chk;
    logic                r_cor_en;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_pass_done;
    logic                r_busy;
    logic                w_mismatch;

    assign w_mismatch = (r_corr != r_data);

    // Scrub sequencer: every output is a register updated on the state
    // transition that enters the state in which it must be valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= c_TMR_RELOAD;
            r_addr      <= '0;
            r_data      <= '0;
            r_chk       <= '0;
            r_corr      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_wchk  <= '0;
            r_cor_din   <= '0;
            r_cor_chk   <= '0;
            r_cor_en    <= 1'b0;
            r_err_cnt   <= '0;
            r_pass_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (scrub_en) begin
                        r_state <= S_WAIT;
                        r_timer <= c_TMR_RELOAD;
                    end
                end
                S_WAIT: begin
                    // Disable aborts the idle gap; address is kept for resume.
                    if (!scrub_en) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == '0) begin
                        r_state   <= S_RD_REQ;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_RD_REQ: begin
                    if (mem.mem_gnt) begin
                        r_state   <= S_RD_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (mem.mem_rvalid) begin
                        r_state   <= S_CORR;
                        r_data    <= mem.mem_rdata;
                        r_chk     <= mem.mem_rchk;
                        r_cor_din <= mem.mem_rdata;
                        r_cor_chk <= mem.mem_rchk;
                        r_cor_en  <= 1'b1;
                    end
                end
                S_CORR: begin
                    r_state   <= S_CMP;
                    r_corr    <= cor_dout;
                    r_cor_din <= '0;
                    r_cor_chk <= '0;
                    r_cor_en  <= 1'b0;
                end
                S_CMP: begin
                    if (!w_mismatch) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_state     <= S_WR_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= r_corr;
                        r_mem_wchk  <= r_chk;
                        if (r_err_cnt != c_CNT_MAX) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (mem.mem_gnt) begin
                        r_state     <= S_NEXT;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                        r_mem_wchk  <= '0;
                    end
                end
                S_NEXT: begin
                    r_busy <= 1'b0;
                    if (r_addr == c_LAST_ADDR) begin
                        r_addr      <= '0;
                        r_pass_done <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                    if (scrub_en) begin
                        r_state <= S_WAIT;
                        r_timer <= c_TMR_RELOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ECC_SCRUB_LOG_EN
    logic              r_log_valid;
    logic [ADDR_W-1:0] r_log_addr;

    // Sticky record of the first corrected address since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_log_valid <= 1'b0;
            r_log_addr  <= '0;
        end else if (r_state == S_CMP && w_mismatch && !r_log_valid) begin
            r_log_valid <= 1'b1;
            r_log_addr  <= r_addr;
        end
    end

    assign log_valid = r_log_valid;
    assign log_addr  = r_log_addr;
`endif

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_wchk  = r_mem_wchk;
    assign cor_din       = r_cor_din;
    assign cor_chk       = r_cor_chk;
    assign cor_en        = r_cor_en;
    assign err_cnt       = r_err_cnt;
    assign pass_done     = r_pass_done;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_scrub_ctrl
// Brief    : Directed bench for ecc_scrub_ctrl (DEPTH=4, INTERVAL=2,
//            CNT_W=2). Provides an SRAM model with error injection and a
//            toy single-error corrector (6-bit position syndrome + parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_scrub_ctrl;

    localparam int c_ADDR_W = 3;
    localparam int c_CNT_W  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               scrub_en = 1'b0;
    logic [31:0]        cor_din;
    logic [7:0]         cor_chk;
    logic               cor_en;
    logic [31:0]        cor_dout;
    logic [c_CNT_W-1:0] err_cnt;
    logic               pass_done;
    logic               busy;

    logic               gnt_en = 1'b1;
    logic               inj_en = 1'b0;
    logic [2:0]         inj_a  = '0;
    logic [31:0]        inj_dm = '0;
    logic [7:0]         inj_cm = '0;

    logic [31:0]        mem_d [8];
    logic [7:0]         mem_c [8];
    int                 rd_cnt = 0, wr_cnt = 0, cyc = 0, last_rd_cyc = 0, rd_gap = 0;
    logic [2:0]         last_ra = '0, last_wa = '0;
    int                 viol = 0, cor_cnt = 0, bad_cor = 0;
    logic               p_pend = 1'b0, p_we = 1'b0;
    logic [2:0]         p_addr = '0;
    logic [31:0]        p_wd = '0;
    logic [7:0]         p_wc = '0;

    int n_assert = 0;
    int n_fail   = 0;

    ecc_scrub_ctrl_if #(.ADDR_W(c_ADDR_W)) mif ();

    ecc_scrub_ctrl #(
        .ADDR_W   (c_ADDR_W),
        .DEPTH    (4),
        .INTERVAL (2),
        .CNT_W    (c_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scrub_en  (scrub_en),
        .mem       (mif.master),
        .cor_din   (cor_din),
        .cor_chk   (cor_chk),
        .cor_en    (cor_en),
        .cor_dout  (cor_dout),
        .err_cnt   (err_cnt),
        .pass_done (pass_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gold(input int i);
        case (i)
            0:       return 32'h1234_5678;
            1:       return 32'hDEAD_BEEF;
            2:       return 32'h0F0F_00FF;
            3:       return 32'hA5A5_5A5A;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [7:0] enc(input logic [31:0] d);
        logic [5:0] x;
        x = '0;
        for (int i = 0; i < 32; i++) if (d[i]) x ^= 6'(i + 1);
        return {1'b0, ^d, x};
    endfunction

    function automatic logic [31:0] corr(input logic [31:0] d, input logic [7:0] c, input logic en);
        logic [7:0] e;
        logic [5:0] s;
        e = enc(d);
        s = e[5:0] ^ c[5:0];
        if (!en) return '0;
        if (e[6] != c[6] && s >= 6'd1 && s <= 6'd32) return d ^ (32'd1 << (s - 6'd1));
        return d;
    endfunction

    assign cor_dout     = corr(cor_din, cor_chk, cor_en);
    assign mif.mem_gnt  = mif.mem_req & gnt_en;

    // SRAM model, access log and read response (one cycle after read grant)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_d[i] <= gold(i);
                mem_c[i] <= enc(gold(i));
            end
        end else begin
            if (inj_en) begin
                mem_d[inj_a] <= mem_d[inj_a] ^ inj_dm;
                mem_c[inj_a] <= mem_c[inj_a] ^ inj_cm;
            end
            if (mif.mem_req && mif.mem_gnt && mif.mem_we) begin
                mem_d[mif.mem_addr] <= mif.mem_wdata;
                mem_c[mif.mem_addr] <= mif.mem_wchk;
                wr_cnt  <= wr_cnt + 1;
                last_wa <= mif.mem_addr;
            end
            if (mif.mem_req && mif.mem_gnt && !mif.mem_we) begin
                rd_cnt      <= rd_cnt + 1;
                last_ra     <= mif.mem_addr;
                rd_gap      <= cyc - last_rd_cyc;
                last_rd_cyc <= cyc;
            end
        end
        mif.mem_rvalid <= mif.mem_req & mif.mem_gnt & ~mif.mem_we & ~rst;
        mif.mem_rdata  <= mem_d[mif.mem_addr];
        mif.mem_rchk   <= mem_c[mif.mem_addr];
    end

    // Request-stability and corrector-idle monitors
    always @(posedge clk) begin
        if (rst) begin
            p_pend <= 1'b0;
        end else begin
            if (p_pend && !(mif.mem_req === 1'b1 && mif.mem_we === p_we && mif.mem_addr === p_addr &&
                            mif.mem_wdata === p_wd && mif.mem_wchk === p_wc))
                viol <= viol + 1;
            p_pend <= mif.mem_req && !mif.mem_gnt;
            p_we   <= mif.mem_we;
            p_addr <= mif.mem_addr;
            p_wd   <= mif.mem_wdata;
            p_wc   <= mif.mem_wchk;
            if (cor_en) cor_cnt <= cor_cnt + 1;
            else if (cor_din != '0 || cor_chk != '0) bad_cor <= bad_cor + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel 0: pass_done, 1: read request, 2: write request
    task automatic wait_ev(input int sel, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel == 0 && pass_done === 1'b1) ||
                (sel == 1 && mif.mem_req === 1'b1 && mif.mem_we === 1'b0) ||
                (sel == 2 && mif.mem_req === 1'b1 && mif.mem_we === 1'b1)) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic inject(input logic [2:0] a, input logic [31:0] dm, input logic [7:0] cm);
        inj_a  = a;
        inj_dm = dm;
        inj_cm = cm;
        inj_en = 1'b1;
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    initial begin
        int r0, w0, c0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req",   64'(mif.mem_req),  64'd0);
        check("rst_addr",  64'(mif.mem_addr), 64'd0);
        check("rst_busy",  64'(busy),         64'd0);
        check("rst_err",   64'(err_cnt),      64'd0);
        check("rst_pass",  64'(pass_done),    64'd0);
        check("rst_coren", 64'(cor_en),       64'd0);

        // Clean pass: 4 reads, no writes, 7-cycle word spacing, wrap to 0
        rst = 1'b0;
        scrub_en = 1'b1;
        r0 = rd_cnt; w0 = wr_cnt; c0 = cor_cnt;
        wait_ev(0, "to_pass1");
        check("p1_reads",  64'(rd_cnt - r0),  64'd4);
        check("p1_writes", 64'(wr_cnt - w0),  64'd0);
        check("p1_err",    64'(err_cnt),      64'd0);
        check("p1_lastra", 64'(last_ra),      64'd3);
        check("p1_wrap",   64'(mif.mem_addr), 64'd0);
        check("p1_gap",    64'(rd_gap),       64'd7);
        check("p1_corcnt", 64'(cor_cnt - c0), 64'd4);
        @(negedge clk);
        check("p1_pulse",  64'(pass_done),    64'd0);

        // Word 2 data bit 5 flipped: single write-back with original check
        inject(3'd2, 32'h0000_0020, 8'h00);
        w0 = wr_cnt;
        wait_ev(0, "to_pass2");
        check("p2_writes", 64'(wr_cnt - w0),  64'd1);
        check("p2_wa",     64'(last_wa),      64'd2);
        check("p2_data",   64'(mem_d[2]),     64'(gold(2)));
        check("p2_chk",    64'(mem_c[2]),     64'(enc(gold(2))));
        check("p2_err",    64'(err_cnt),      64'd1);

        // Check-bit-only error on word 1: not detected, no write-back
        inject(3'd1, 32'h0, 8'h04);
        w0 = wr_cnt;
        wait_ev(0, "to_pass3");
        check("p3_writes", 64'(wr_cnt - w0),  64'd0);
        check("p3_err",    64'(err_cnt),      64'd1);

        // Grant withheld 7 cycles on read of addr 0
        gnt_en = 1'b0;
        inject(3'd1, 32'h0002_0000, 8'h04);   // restore check, corrupt data bit 17
        r0 = rd_cnt;
        wait_ev(1, "to_rdreq");
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_req",  64'(mif.mem_req),  64'd1);
            check("hold_addr", 64'(mif.mem_addr), 64'd0);
        end
        gnt_en = 1'b1;
        @(negedge clk);
        check("hold_reads", 64'(rd_cnt - r0),  64'd1);
        check("hold_drop",  64'(mif.mem_req),  64'd0);

        // scrub_en dropped during WR_REQ of word 1
        w0 = wr_cnt;
        wait_ev(2, "to_wrreq");
        check("wr_addr",  64'(mif.mem_addr),  64'd1);
        check("wr_data",  64'(mif.mem_wdata), 64'(gold(1)));
        check("wr_chk",   64'(mif.mem_wchk),  64'(enc(gold(1))));
        scrub_en = 1'b0;
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        check("off_writes", 64'(wr_cnt - w0),  64'd1);
        check("off_reads",  64'(rd_cnt - r0),  64'd0);
        check("off_busy",   64'(busy),         64'd0);
        check("off_addr",   64'(mif.mem_addr), 64'd2);
        check("off_err",    64'(err_cnt),      64'd2);

        // Resume at addr 2; corrupt every word so the 2-bit counter saturates
        inject(3'd0, 32'h0000_0001, 8'h00);
        inject(3'd1, 32'h8000_0000, 8'h00);
        inject(3'd2, 32'h0000_0020, 8'h00);
        inject(3'd3, 32'h0000_1000, 8'h00);
        w0 = wr_cnt;
        scrub_en = 1'b1;
        wait_ev(1, "to_resume");
        @(negedge clk);
        check("resume_ra", 64'(last_ra), 64'd2);
        wait_ev(0, "to_pass4");
        check("sat_err1", 64'(err_cnt), 64'd3);
        wait_ev(0, "to_pass5");
        check("sat_err2",   64'(err_cnt),     64'd3);
        check("sat_writes", 64'(wr_cnt - w0), 64'd4);
        for (int i = 0; i < 4; i++) check("sat_mem", 64'(mem_d[i]), 64'(gold(i)));

        // Asynchronous reset while waiting for read data of addr 1
        wait_ev(1, "to_rd0");
        @(negedge clk);
        wait_ev(1, "to_rd1");
        @(negedge clk);
        check("pre_busy", 64'(busy),         64'd1);
        check("pre_addr", 64'(mif.mem_addr), 64'd1);
        rst = 1'b1;
        #1;
        check("ar_req",   64'(mif.mem_req),   64'd0);
        check("ar_we",    64'(mif.mem_we),    64'd0);
        check("ar_addr",  64'(mif.mem_addr),  64'd0);
        check("ar_wdata", 64'(mif.mem_wdata), 64'd0);
        check("ar_busy",  64'(busy),          64'd0);
        check("ar_coren", 64'(cor_en),        64'd0);
        check("ar_err",   64'(err_cnt),       64'd0);
        check("ar_pass",  64'(pass_done),     64'd0);
        scrub_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = rd_cnt;
        repeat (5) @(negedge clk);
        check("post_busy",  64'(busy),         64'd0);
        check("post_reads", 64'(rd_cnt - r0),  64'd0);
        scrub_en = 1'b1;
        wait_ev(1, "to_rd_after_rst");
        @(negedge clk);
        check("post_ra",    64'(last_ra),      64'd0);

        check("stability", 64'(viol),    64'd0);
        check("cor_idle",  64'(bad_cor), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
